// File: rtl/appr_mag_peak.sv
// appr_mag_peak: 3-stage alpha-max-plus-beta-min magnitude with windowed peak detector.
module appr_mag_peak #(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [WIDTH-1:0]    real_in,
  input  logic [WIDTH-1:0]    imag_in,
  input  logic [1:0]          mode,
  input  logic                clr,
  output logic [WIDTH:0]      mag,
  output logic                val,
  output logic [WIDTH:0]      pk_mag,
  output logic [WIN_LOG2-1:0] pk_idx,
  output logic                pk_val
);
  logic                v1_q, v2_q, v3_q;
  logic [WIDTH-1:0]    are_q, are_d, aim_q, aim_d, max_q, max_d, min_q, min_d;
  logic [1:0]          md1_q, md1_d, md2_q, md2_d;
  logic [WIDTH:0]      mag_q, mag_d, mx, mn, m0, m1, m2, m3;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d, ecnt, run_idx_q, run_idx_d, ni, pk_idx_q, pk_idx_d;
  logic [WIDTH:0]      run_pk_q, run_pk_d, np, pk_mag_q, pk_mag_d;
  logic                pk_val_d, upd;

  always_comb begin
    are_d = ena ? (real_in[WIDTH-1] ? WIDTH'(-real_in) : real_in) : are_q;
    aim_d = ena ? (imag_in[WIDTH-1] ? WIDTH'(-imag_in) : imag_in) : aim_q;
    md1_d = ena ? mode : md1_q;
    max_d = v1_q ? ((are_q >= aim_q) ? are_q : aim_q) : max_q;
    min_d = v1_q ? ((are_q >= aim_q) ? aim_q : are_q) : min_q;
    md2_d = v1_q ? md1_q : md2_q;
    mx    = {1'b0, max_q};
    mn    = {1'b0, min_q};
    m0    = mx + (mn >> 1);
    m1    = mx + (mn >> 2);
    m2    = mx + (mn >> 2) + (mn >> 3);
    m3    = (mx - (mx >> 4)) + ((mn >> 1) - (mn >> 5));
    mag_d = !v2_q ? mag_q : md2_q == 2'd0 ? m0 : md2_q == 2'd1 ? m1 : md2_q == 2'd2 ? m2 : m3;
  end

  // A clr in the same cycle as a valid sample makes that sample index 0.
  always_comb begin
    ecnt      = clr ? '0 : cnt_q;
    upd       = (ecnt == '0) || (mag_q > run_pk_q);
    np        = upd ? mag_q : run_pk_q;
    ni        = upd ? ecnt : run_idx_q;
    cnt_d     = v3_q ? ecnt + WIN_LOG2'(1) : ecnt;
    run_pk_d  = v3_q ? np : run_pk_q;
    run_idx_d = v3_q ? ni : run_idx_q;
    pk_val_d  = v3_q && (ecnt == '1);
    pk_mag_d  = pk_val_d ? np : pk_mag_q;
    pk_idx_d  = pk_val_d ? ni : pk_idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      are_q     <= '0;
      aim_q     <= '0;
      md1_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      md2_q     <= '0;
      mag_q     <= '0;
      cnt_q     <= '0;
      run_pk_q  <= '0;
      run_idx_q <= '0;
      pk_mag_q  <= '0;
      pk_idx_q  <= '0;
      pk_val    <= 1'b0;
    end else begin
      v1_q      <= ena;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      are_q     <= are_d;
      aim_q     <= aim_d;
      md1_q     <= md1_d;
      max_q     <= max_d;
      min_q     <= min_d;
      md2_q     <= md2_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      run_pk_q  <= run_pk_d;
      run_idx_q <= run_idx_d;
      pk_mag_q  <= pk_mag_d;
      pk_idx_q  <= pk_idx_d;
      pk_val    <= pk_val_d;
    end
  end

  assign mag    = mag_q;
  assign val    = v3_q;
  assign pk_mag = pk_mag_q;
  assign pk_idx = pk_idx_q;
endmodule
